// File: rtl/alu_pkg.sv
// Shared opcode map, shifter mode codes and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_FWD  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_LAST = 4'd8;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter/rotator with defined results for every shift amount.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] amount,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    logic          big;
    logic [SW-1:0] sh;
    logic [SW-1:0] rot;

    // Amounts below WIDTH always fit in SW bits, so truncation is safe when !big.
    assign big = (amount >= W_VAL);
    assign sh  = SW'(amount);
    assign rot = SW'(amount % W_VAL);

    always_comb begin
        result = '0;
        case (mode)
            SH_SLL: result = big ? '0 : (data << sh);
            SH_SRL: result = big ? '0 : (data >> sh);
            SH_SRA: result = big ? {WIDTH{data[WIDTH-1]}} : WIDTH'($signed(data) >>> sh);
            default: result = WIDTH'({data, data} >> rot);
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops, radix-2 shift-add multiplier, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [3:0]       SELECT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVF,
    output logic             ILLEGAL,
    output logic [1:0]       DBG_STATE
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic             in_ready;
    logic             accept;
    logic             take;
    logic [1:0]       shift_mode;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] op_res;
    logic             op_carry, op_ovf, op_ill;
    logic [WIDTH-1:0] acc_step;
    logic             mul_last;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY);
    assign accept   = IN_VALID && in_ready;
    assign take     = out_valid_q && OUT_READY;

    always_comb begin
        shift_mode = SH_SLL;
        case (SELECT)
            OP_SRL:  shift_mode = SH_SRL;
            OP_SRA:  shift_mode = SH_SRA;
            OP_ROR:  shift_mode = SH_ROR;
            default: shift_mode = SH_SLL;
        endcase
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .data   (DATA1),
        .amount (DATA2),
        .mode   (shift_mode),
        .result (shift_res)
    );

    // Single-cycle ops are evaluated straight from the inputs and land in the output register at accept.
    always_comb begin
        sum      = {1'b0, DATA1} + {1'b0, DATA2};
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_ill   = 1'b0;
        case (SELECT)
            OP_FWD: op_res = DATA2;
            OP_ADD: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
                op_ovf   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum[WIDTH-1] != DATA1[WIDTH-1]);
            end
            OP_AND: op_res = DATA1 & DATA2;
            OP_OR:  op_res = DATA1 | DATA2;
            OP_MUL: op_res = '0;
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: op_res = shift_res;
            default: op_ill = 1'b1;
        endcase
    end

    // Low WIDTH bits of the unsigned product equal those of the signed product.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (mul_last) begin
                    state_d     = S_DONE;
                    cnt_d       = '0;
                    result_d    = acc_step;
                    zero_d      = (acc_step == '0);
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                if (take) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
                if (accept) begin
                    if (SELECT == OP_MUL) begin
                        state_d     = S_MUL;
                        mcand_d     = DATA1;
                        mplier_d    = DATA2;
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = S_DONE;
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        carry_d     = op_carry;
                        ovf_d       = op_ovf;
                        illegal_d   = op_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign CARRY     = carry_q;
    assign OVF       = ovf_q;
    assign ILLEGAL   = illegal_q;
    assign DBG_STATE = state_q;

endmodule
